// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: operation enum, opcode/funct codes, NOP word
// and the pure request-to-word encoder used by the instruction loader.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_SLT  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,  OP_LW   = 5'd9,  OP_SW   = 5'd10, OP_BEQ  = 5'd11,
    OP_BNE  = 5'd12, OP_ADDI = 5'd13, OP_ANDI = 5'd14, OP_ORI  = 5'd15,
    OP_XORI = 5'd16, OP_LUI  = 5'd17, OP_J    = 5'd18
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic op_is_legal(input logic [4:0] op);
    return op <= 5'd18;
  endfunction

  function automatic logic [31:0] encode_instr(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        is_shift;
    logic [31:0] word;
    opc      = OPC_RTYPE;
    fn       = 6'b0;
    is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    case (op)
      OP_ADD:  fn  = FN_ADD;
      OP_SUB:  fn  = FN_SUB;
      OP_AND:  fn  = FN_AND;
      OP_OR:   fn  = FN_OR;
      OP_XOR:  fn  = FN_XOR;
      OP_SLT:  fn  = FN_SLT;
      OP_SLL:  fn  = FN_SLL;
      OP_SRL:  fn  = FN_SRL;
      OP_SRA:  fn  = FN_SRA;
      OP_LW:   opc = OPC_LW;
      OP_SW:   opc = OPC_SW;
      OP_BEQ:  opc = OPC_BEQ;
      OP_BNE:  opc = OPC_BNE;
      OP_ADDI: opc = OPC_ADDI;
      OP_ANDI: opc = OPC_ANDI;
      OP_ORI:  opc = OPC_ORI;
      OP_XORI: opc = OPC_XORI;
      OP_LUI:  opc = OPC_LUI;
      OP_J:    opc = OPC_J;
      default: opc = OPC_RTYPE;
    endcase
    // Shifts take their operand from rt, so rs is zeroed; others never carry shamt.
    if (!op_is_legal(op))
      word = NOP_WORD;
    else if (op <= OP_SRA)
      word = {OPC_RTYPE, is_shift ? 5'd0 : rs, rt, rd, is_shift ? shamt : 5'd0, fn};
    else if (op == OP_J)
      word = {opc, target};
    else
      word = {opc, (op == OP_LUI) ? 5'd0 : rs, rt, imm};
    return word;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with full/empty flags; write-through is not supported,
// a pushed word is visible at the head on the following cycle.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into MIPS words and streams them into
// instruction memory from a base address, buffered by a small word FIFO.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [15:0]       i_count,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [4:0]        i_in_op,
  input  logic [4:0]        i_in_rs,
  input  logic [4:0]        i_in_rt,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_shamt,
  input  logic [15:0]       i_in_imm,
  input  logic [25:0]       i_in_target,
  output logic              o_imem_we,
  input  logic              i_imem_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_illegal
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic [15:0]       r_acc;
  logic [15:0]       r_wr;
  logic              r_err;

  logic        w_full, w_empty, w_push, w_pop;
  logic [31:0] w_word, w_head;
  logic [15:0] w_acc_next, w_wr_next;
  logic        w_unused;

  assign w_unused     = ^i_base_addr[1:0];
  assign o_in_ready   = (r_state == S_LOAD) && !w_full && (r_acc < r_count);
  assign o_imem_we    = !w_empty && ((r_state == S_LOAD) || (r_state == S_DRAIN));
  assign w_push       = i_in_valid && o_in_ready;
  assign w_pop        = o_imem_we && i_imem_ready;
  assign w_acc_next   = r_acc + {15'd0, w_push};
  assign w_wr_next    = r_wr + {15'd0, w_pop};
  assign w_word       = encode_instr(i_in_op, i_in_rs, i_in_rt, i_in_rd, i_in_shamt,
                                     i_in_imm, i_in_target);
  assign o_imem_wdata = w_head;
  assign o_imem_addr  = r_addr;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_err_illegal = r_err;

  word_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (w_word),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_wr    <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_acc <= w_acc_next;
      if (w_pop) begin
        r_wr   <= w_wr_next;
        r_addr <= r_addr + ADDR_W'(4);
      end
      if (w_push && !op_is_legal(i_in_op)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_addr  <= {i_base_addr[ADDR_W-1:2], 2'b00};
          r_count <= i_count;
          r_acc   <= '0;
          r_wr    <= '0;
          r_err   <= 1'b0;
          r_state <= (i_count == 16'd0) ? S_DONE : S_LOAD;
        end
        S_LOAD: begin
          if (w_wr_next == r_count)       r_state <= S_DONE;
          else if (w_acc_next == r_count) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_wr_next == r_count) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: table vectors from the instruction set definition plus
// randomized jobs checked against an arithmetic reference encoder and memory model.
module tb_instr_encoder_loader;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 32;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } req_t;

  logic              i_clk, i_rst_n, i_start, i_in_valid, i_imem_ready;
  logic [ADDR_W-1:0] i_base_addr;
  logic [15:0]       i_count, i_in_imm;
  logic [4:0]        i_in_op, i_in_rs, i_in_rt, i_in_rd, i_in_shamt;
  logic [25:0]       i_in_target;
  logic              o_in_ready, o_imem_we, o_busy, o_done, o_err_illegal;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  req_t req_q[$];
  req_t tbl[8];

  instr_encoder_loader #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_op(i_in_op), .i_in_rs(i_in_rs), .i_in_rt(i_in_rt), .i_in_rd(i_in_rd),
    .i_in_shamt(i_in_shamt), .i_in_imm(i_in_imm), .i_in_target(i_in_target),
    .o_imem_we(o_imem_we), .i_imem_ready(i_imem_ready), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_err_illegal(o_err_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder: opcode/funct looked up by op number, fields placed by weight.
  function automatic logic [31:0] ref_encode(input req_t r);
    int unsigned funct_tab[9];
    int unsigned opc_tab[9];
    int unsigned w;
    int unsigned op;
    funct_tab = '{32, 34, 36, 37, 38, 42, 0, 2, 3};
    opc_tab   = '{35, 43, 4, 5, 8, 12, 13, 14, 15};
    op = r.op;
    if (op <= 8) begin
      w = (op >= 6) ? 0 : r.rs * (1 << 21);
      w = w + r.rt * (1 << 16) + r.rd * (1 << 11) + funct_tab[op];
      if (op >= 6) w = w + r.shamt * (1 << 6);
    end else if (op <= 17) begin
      w = opc_tab[op-9] * (1 << 26) + r.rt * (1 << 16) + r.imm;
      if (op != 17) w = w + r.rs * (1 << 21);
    end else if (op == 18) begin
      w = 2 * (1 << 26) + r.target;
    end else begin
      w = 0;
    end
    return w;
  endfunction

  function automatic req_t mk(input int op, input int rs, input int rt, input int rd,
                              input int sh, input int imm, input int tgt, input logic [31:0] exp);
    req_t r;
    r.op = op[4:0]; r.rs = rs[4:0]; r.rt = rt[4:0]; r.rd = rd[4:0];
    r.shamt = sh[4:0]; r.imm = imm[15:0]; r.target = tgt[25:0]; r.exp = exp;
    return r;
  endfunction

  task automatic gen_random(input int n, input bit allow_illegal);
    req_t r;
    req_q.delete();
    for (int i = 0; i < n; i++) begin
      r.op     = allow_illegal ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 18));
      r.rs     = 5'($urandom);
      r.rt     = 5'($urandom);
      r.rd     = 5'($urandom);
      r.shamt  = 5'($urandom);
      r.imm    = 16'($urandom);
      r.target = 26'($urandom);
      r.exp    = ref_encode(r);
      req_q.push_back(r);
    end
  endtask

  task automatic drive_req(input req_t r);
    i_in_op = r.op; i_in_rs = r.rs; i_in_rt = r.rt; i_in_rd = r.rd;
    i_in_shamt = r.shamt; i_in_imm = r.imm; i_in_target = r.target;
  endtask

  // Runs one load job of req_q; memory writes checked in order against the queue.
  task automatic run_job(input logic [31:0] base, input int n, input int vld_pct,
                         input int rdy_pct, input int hold);
    logic [31:0] exp_q[$];
    logic [31:0] abase, prev_addr, prev_data;
    int acc = 0, wr = 0, cyc = 0, last_wr = -10;
    bit exp_err = 0, seen_done = 0, prev_stall = 0;
    abase = {base[31:2], 2'b00};
    @(negedge i_clk);
    i_start = 1; i_base_addr = base; i_count = n[15:0]; i_in_valid = 0; i_imem_ready = 0;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 0;
    check("start_busy", 32'(o_busy), 1);
    check("start_addr", o_imem_addr, abase);
    check("start_err_clear", 32'(o_err_illegal), 0);
    while (cyc < 2000) begin
      i_in_valid = (acc < n) && ($urandom_range(1, 100) <= vld_pct);
      if (acc < n) drive_req(req_q[acc]);
      i_imem_ready = (cyc >= hold) && ($urandom_range(1, 100) <= rdy_pct);
      #1;
      if (o_done) begin seen_done = 1; break; end
      if (hold > 0 && cyc == hold) begin
        check("hold_accepts", acc, (n < FIFO_DEPTH) ? n : FIFO_DEPTH);
        check("hold_in_ready", 32'(o_in_ready), 0);
      end
      if (prev_stall) begin
        check("stall_we", 32'(o_imem_we), 1);
        check("stall_addr", o_imem_addr, prev_addr);
        check("stall_data", o_imem_wdata, prev_data);
      end
      if (o_in_ready && acc >= n) check("ready_past_count", 32'(o_in_ready), 0);
      if (i_in_valid && o_in_ready) begin
        exp_q.push_back(req_q[acc].exp);
        if (req_q[acc].op >= 19) exp_err = 1;
        acc++;
      end
      if (o_imem_we && i_imem_ready) begin
        if (wr < exp_q.size()) check("wdata", o_imem_wdata, exp_q[wr]);
        else check("write_without_accept", wr, exp_q.size());
        check("waddr", o_imem_addr, abase + 32'(4 * wr));
        wr++;
        last_wr = cyc;
      end
      prev_stall = o_imem_we && !i_imem_ready;
      prev_addr  = o_imem_addr;
      prev_data  = o_imem_wdata;
      @(posedge i_clk); @(negedge i_clk);
      cyc++;
    end
    i_in_valid = 0; i_imem_ready = 0;
    if (!seen_done) begin
      check("done_timeout", 32'(seen_done), 1);
    end else begin
      check("done_writes", wr, n);
      check("done_accepts", acc, n);
      check("done_err", 32'(o_err_illegal), 32'(exp_err));
      check("done_busy", 32'(o_busy), 1);
      if (n > 0) check("done_latency", cyc, last_wr + 1);
      else check("done_zero_count_cycle", cyc, 0);
      if (vld_pct == 100 && rdy_pct == 100 && hold == 0 && n > 0)
        check("throughput", cyc, n + 1);
    end
    @(posedge i_clk); @(negedge i_clk); #1;
    check("done_pulse_end", 32'(o_done), 0);
    check("busy_end", 32'(o_busy), 0);
  endtask

  task automatic reset_midload();
    int acc = 0, wr = 0, cyc = 0, late = 0;
    gen_random(5, 0);
    @(negedge i_clk);
    i_start = 1; i_base_addr = 32'h40; i_count = 16'd5;
    @(posedge i_clk); @(negedge i_clk);
    i_start = 0; i_in_valid = 1; i_imem_ready = 1;
    while (wr < 2 && cyc < 50) begin
      if (acc < 5) drive_req(req_q[acc]);
      i_in_valid = (acc < 5);
      #1;
      if (i_in_valid && o_in_ready) acc++;
      if (o_imem_we && i_imem_ready) wr++;
      @(posedge i_clk); @(negedge i_clk);
      cyc++;
    end
    check("rst_two_writes", wr, 2);
    i_rst_n = 0;
    #1;
    check("rst_in_ready", 32'(o_in_ready), 0);
    check("rst_we", 32'(o_imem_we), 0);
    check("rst_addr", o_imem_addr, 0);
    check("rst_wdata", o_imem_wdata, 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    @(negedge i_clk);
    i_rst_n = 1;
    i_in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (o_imem_we || o_in_ready || o_busy) late++;
      @(negedge i_clk);
    end
    check("rst_no_activity_after", late, 0);
    i_in_valid = 0; i_imem_ready = 0;
  endtask

  initial begin
    i_rst_n = 0; i_start = 0; i_base_addr = '0; i_count = '0; i_in_valid = 0;
    i_imem_ready = 0; i_in_op = '0; i_in_rs = '0; i_in_rt = '0; i_in_rd = '0;
    i_in_shamt = '0; i_in_imm = '0; i_in_target = '0;
    repeat (3) @(negedge i_clk);
    check("reset_in_ready", 32'(o_in_ready), 0);
    check("reset_we", 32'(o_imem_we), 0);
    check("reset_addr", o_imem_addr, 0);
    check("reset_wdata", o_imem_wdata, 0);
    check("reset_busy", 32'(o_busy), 0);
    check("reset_done", 32'(o_done), 0);
    check("reset_err", 32'(o_err_illegal), 0);
    i_rst_n = 1;

    //          op  rs  rt  rd  sh  imm     tgt   expected
    tbl[0] = mk(0,  1,  2,  3,  0,  0,      0,    32'h0022_1820); // ADD
    tbl[1] = mk(13, 0,  8,  0,  0,  5,      0,    32'h2008_0005); // ADDI
    tbl[2] = mk(9,  29, 9,  0,  0,  4,      0,    32'h8FA9_0004); // LW
    tbl[3] = mk(18, 0,  0,  0,  0,  0,      16,   32'h0800_0010); // J
    tbl[4] = mk(6,  7,  1,  2,  4,  0,      0,    32'h0001_1100); // SLL, rs ignored
    tbl[5] = mk(1,  3,  4,  5,  9,  0,      0,    32'h0064_2822); // SUB, shamt ignored
    tbl[6] = mk(17, 5,  6,  0,  0,  'hABCD, 0,    32'h3C06_ABCD); // LUI, rs ignored
    tbl[7] = mk(25, 1,  2,  3,  4,  'h1234, 5,    32'h0000_0000); // illegal -> NOP

    req_q.delete(); req_q.push_back(tbl[0]);
    run_job(32'h100, 1, 100, 100, 0);
    req_q.delete();
    for (int i = 1; i <= 3; i++) req_q.push_back(tbl[i]);
    run_job(32'h0, 3, 100, 100, 0);
    req_q.delete();
    for (int i = 4; i <= 7; i++) req_q.push_back(tbl[i]);
    run_job(32'h203, 4, 70, 60, 0);

    req_q.delete();
    run_job(32'h500, 0, 100, 100, 0);

    gen_random(6, 0);
    run_job(32'h1000, 6, 100, 100, 8);
    gen_random(8, 0);
    run_job(32'h2000, 8, 100, 100, 0);
    gen_random(5, 1);
    run_job(32'hFFFF_FFF8, 5, 80, 80, 0);

    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 20);
      gen_random(n, 1);
      run_job($urandom, n, $urandom_range(30, 100), $urandom_range(20, 100), 0);
    end

    reset_midload();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encoder-side counterpart to the processor's instruction decode: accepts symbolic instruction requests (operation enum plus register/immediate fields), packs them into 32-bit MIPS words and writes them sequentially into instruction memory from a programmable base address. It sits between a test/boot host and the instruction memory write port. It decouples the request handshake from memory back-pressure with a 4-entry word FIFO.

## Interface
- `FIFO_DEPTH`, 4: encoded-word buffer entries (power of two, ≥2).
- `ADDR_W`, 32: instruction memory byte-address width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse; latches `base_addr` and `count`. Ignored unless IDLE.
- `base_addr` input ADDR_W: first write byte address (bits [1:0] ignored, treated as 0).
- `count` input 16: number of instructions to load.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid & in_ready`.
- `in_op` input 5: operation enum.
- `in_rs`, `in_rt`, `in_rd` input 5 each: register fields.
- `in_shamt` input 5: shift amount.
- `in_imm` input 16: I-type immediate.
- `in_target` input 26: J-type target.
- `imem_we` output 1: write request.
- `imem_ready` input 1: memory accepts write this cycle.
- `imem_addr` output ADDR_W: byte address.
- `imem_wdata` output 32: encoded word.
- `busy` output 1: not IDLE.
- `done` output 1: one-cycle pulse, all `count` words written.
- `err_illegal` output 1: sticky; an undefined `in_op` was accepted. Cleared by `start`.

## Operation
- Op enum → fields (opcode/funct binary). Values 0–8 are R-type with opcode 000000: 0 ADD 100000, 1 SUB 100010, 2 AND 100100, 3 OR 100101, 4 XOR 100110, 5 SLT 101010, 6 SLL 000000, 7 SRL 000010, 8 SRA 000011.
- Values 9–17 are I-type: 9 LW 100011, 10 SW 101011, 11 BEQ 000100, 12 BNE 000101, 13 ADDI 001000, 14 ANDI 001100, 15 ORI 001101, 16 XORI 001110, 17 LUI 001111.
- Value 18 is J 000010.
- R-type layout: {opcode, rs, rt, rd, shamt, funct}.
  - Shamt is forced 0 except for SLL/SRL/SRA.
  - Rs is forced 0 for SLL/SRL/SRA.
- I-type layout: {opcode, rs, rt, imm}. Rs is forced 0 for LUI.
- J-type layout: {opcode, target}.
- Ops 19–31 encode as 0x00000000 (NOP), set `err_illegal`, and still count toward `count`.
- FSM states:
  - IDLE: `start` → LOAD, or → DONE if `count`==0.
  - LOAD: accepts requests.
    - When accepted==`count`, go to DRAIN.
    - If that same cycle also completes the last memory write, go directly to DONE.
  - DRAIN: FIFO emptying, no new accepts. Last write handshake → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `in_ready` = LOAD & FIFO not full & accepted < `count`.
  - A FIFO-full check blocks a push even when a pop happens the same cycle; this is decided and intentional.
- `imem_we` = FIFO non-empty & (LOAD | DRAIN).
- `imem_wdata` = FIFO head.
- A write completes on `imem_we & imem_ready`: the FIFO pops and `imem_addr` += 4.
- `imem_addr` wraps modulo 2^ADDR_W.
- Accepted and written counters are 16 bits, cleared on `start`.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `busy` 0, `done` 0, `err_illegal` 0. State is IDLE and the FIFO is empty.
- `start` in cycle t: `busy`=1 and `imem_addr`=`base_addr` from t+1; `in_ready` may be high from t+1.
- Encoding latency: a request accepted in cycle t has its word written into the FIFO at the end of t. `imem_we` with that word is visible at t+1 at the earliest.
- With `imem_ready` held high and continuous `in_valid`, throughput is one word per cycle.
- `imem_we`, `imem_addr` and `imem_wdata` stay stable while `imem_ready`=0.
- `done` is asserted the cycle after the final write handshake. `busy` falls in the same cycle `done` falls.
- Asynchronous reset mid-load: everything returns to reset values immediately. Words already written remain in memory, and no further writes occur.

## Structure
- Shared package `mips_isa_pkg` holds:
  - the op enum type and its 19 values;
  - the opcode/funct localparams, which are also used by the control decoder;
  - the NOP constant.
- Sub-module `word_fifo`: parameterised synchronous FIFO with full/empty flags. The encoder is a pure function in the package or an inline combinational block.

## Test plan
- ADD rs=1 rt=2 rd=3, with `base_addr`=0x100 and `count`=1: one write of 0x00221820 at 0x100, then `done` pulses.
- ADDI rs=0 rt=8 imm=5, then LW rs=29 rt=9 imm=4, then J target=0x10, with `count`=3: writes 0x20080005, 0x8FA90004 and 0x08000010 at 0x0, 0x4 and 0x8.
- SLL rt=1 rd=2 shamt=4 with `in_rs`=7: 0x00011100 (rs forced 0).
- Hold `imem_ready`=0 with `count`=6: exactly 4 accepts, then `in_ready`=0 and the `imem_we` data is held. Releasing `imem_ready` drains in order and all 6 words land.
- `in_op`=25: 0x00000000 is written and `err_illegal`=1 until the next `start`. `start` with `count`=0: `done` on t+1, no writes.
- Assert `rst_n` low after 2 of 5 writes: outputs return to 0 immediately. After release there are no writes until a new `start`.
